// File: rtl/mc_control_unit_pkg.sv
// Purpose: shared encodings for the multicycle control unit (states, ALU codes, mux selects, opcodes).
// Latency: n/a (types, constants and pure combinational helpers only).
// Backpressure: n/a. MC_JAL_EN adds the JAL state and makes opcode 1101111 legal.
package mc_control_unit_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
`ifdef MC_JAL_EN
        ,
        S_JAL      = 4'd10
`endif
    } state_t;

    // ALU operation class handed to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALUControl codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SLL = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b111;

    // Datapath mux selects
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;
    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_RESULT = 1'b1;
    localparam logic [1:0] IMM_I      = 2'b00;
    localparam logic [1:0] IMM_S      = 2'b01;
    localparam logic [1:0] IMM_B      = 2'b10;
    localparam logic [1:0] IMM_J      = 2'b11;

    // Opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Opcodes the DECODE state can dispatch; anything else is flagged illegal
    function automatic logic opcode_supported(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH: return 1'b1;
`ifdef MC_JAL_EN
            OP_JAL:                                           return 1'b1;
`endif
            default:                                          return 1'b0;
        endcase
    endfunction

    // Immediate format is a pure function of the opcode
    function automatic logic [1:0] imm_src(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

    // funct3 010/011 (slt/sltu) have no ALU code and are rejected in EXEC
    function automatic logic funct3_reserved(input logic [2:0] f3);
        return f3[2:1] == 2'b01;
    endfunction

endpackage

// File: rtl/mc_control_unit_alu_decoder.sv
// Purpose: maps ALU operation class plus funct3/funct7b5 to the ALUControl code.
// Latency: purely combinational.
// Backpressure: none; caller gates funct7b5 so only R-type can select sub.
module alu_decoder
    import mc_control_unit_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    // Fixed add/sub for address and branch work, funct3 table for ALU instructions
    always_comb begin
        alu_control = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = funct7b5 ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Purpose: multicycle RISC-V control FSM (Moore; PCWrite/IRWrite also follow mem_ready/ZF/SF). Macro MC_JAL_EN enables jal.
// Latency: 4 cycles for ALU ops and branches' 3, loads 5, stores 4, plus one per mem_ready-low cycle.
// Backpressure: mem_ready low holds FETCH, MEMREAD and MEMWRITE; all outputs are 0 while rst_n is low.
module mc_control_unit
    import mc_control_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       ZF,
    input  logic       SF,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal_op
);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] aluop;
    logic       rtype_f7b5;
    logic       branch_taken;

    // Only R-type may turn funct3 000 into sub; I-type addi keeps bit 30 as immediate
    assign rtype_f7b5 = funct7b5 && (opcode == OP_RTYPE);

    always_comb begin
        case (funct3)
            3'b000:  branch_taken = ZF;
            3'b001:  branch_taken = !ZF;
            3'b100:  branch_taken = SF;
            default: branch_taken = 1'b0;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop       (aluop),
        .funct3      (funct3),
        .funct7b5    (rtype_f7b5),
        .alu_control (ALUControl)
    );

    // State register; reset parks the FSM in FETCH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nxt;
    end

    // Next-state sequencing
    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_FETCH:    state_nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
                    OP_RTYPE:          state_nxt = S_EXECR;
                    OP_ITYPE:          state_nxt = S_EXECI;
                    OP_BRANCH:         state_nxt = S_BRANCH;
`ifdef MC_JAL_EN
                    OP_JAL:            state_nxt = S_JAL;
`endif
                    default:           state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR:   state_nxt = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_nxt = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_nxt = S_FETCH;
            S_MEMWRITE: state_nxt = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR,
            S_EXECI:    state_nxt = funct3_reserved(funct3) ? S_FETCH : S_ALUWB;
            S_ALUWB:    state_nxt = S_FETCH;
            S_BRANCH:   state_nxt = S_FETCH;
`ifdef MC_JAL_EN
            S_JAL:      state_nxt = S_ALUWB;
`endif
            default:    state_nxt = S_FETCH;
        endcase
    end

    // Per-state datapath controls; everything held at 0 while in reset
    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = ADR_PC;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_B;
        ResultSrc  = RES_ALUOUT;
        ImmSrc     = IMM_I;
        aluop      = ALUOP_ADD;
        illegal_op = 1'b0;
        if (rst_n) begin
            ImmSrc = imm_src(opcode);
            case (state)
                S_FETCH: begin
                    AdrSrc    = ADR_PC;
                    ALUSrcA   = SRCA_PC;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALURES;
                    IRWrite   = mem_ready;
                    PCWrite   = mem_ready;
                end
                S_DECODE: begin
                    ALUSrcA    = SRCA_OLDPC;
                    ALUSrcB    = SRCB_IMM;
                    illegal_op = !opcode_supported(opcode);
                end
                S_MEMADR: begin
                    ALUSrcA = SRCA_A;
                    ALUSrcB = SRCB_IMM;
                end
                S_MEMREAD: begin
                    AdrSrc    = ADR_RESULT;
                    ResultSrc = RES_ALUOUT;
                end
                S_MEMWB: begin
                    ResultSrc = RES_DATA;
                    RegWrite  = 1'b1;
                end
                S_MEMWRITE: begin
                    AdrSrc    = ADR_RESULT;
                    ResultSrc = RES_ALUOUT;
                    MemWrite  = 1'b1;
                end
                S_EXECR: begin
                    ALUSrcA    = SRCA_A;
                    ALUSrcB    = SRCB_B;
                    aluop      = ALUOP_FUNCT;
                    illegal_op = funct3_reserved(funct3);
                end
                S_EXECI: begin
                    ALUSrcA    = SRCA_A;
                    ALUSrcB    = SRCB_IMM;
                    aluop      = ALUOP_FUNCT;
                    illegal_op = funct3_reserved(funct3);
                end
                S_ALUWB: begin
                    ResultSrc = RES_ALUOUT;
                    RegWrite  = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA   = SRCA_A;
                    ALUSrcB   = SRCB_B;
                    aluop     = ALUOP_SUB;
                    ResultSrc = RES_ALUOUT;
                    PCWrite   = branch_taken;
                end
`ifdef MC_JAL_EN
                S_JAL: begin
                    ALUSrcA   = SRCA_OLDPC;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALUOUT;
                    PCWrite   = 1'b1;
                end
`endif
                default: begin
                    PCWrite = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Purpose: randomized self-checking bench for mc_control_unit against a per-instruction cycle plan.
// Latency: each planned step is one clock; inputs change on negedge, outputs sampled 2 time units later.
// Backpressure: mem_ready wait cycles are chosen per instruction and folded into the plan.
module tb_mc_control_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'b0110011;
    logic [2:0] funct3 = 3'b000;
    logic       funct7b5 = 1'b0;
    logic       ZF = 1'b0;
    logic       SF = 1'b0;
    logic       mem_ready = 1'b1;
    logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, illegal_op;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0] ALUControl;

    always #5 clk = ~clk;

    mc_control_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .ZF         (ZF),
        .SF         (SF),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .illegal_op (illegal_op)
    );

    typedef struct packed {
        logic       pcw;
        logic       irw;
        logic       rw;
        logic       mw;
        logic       adr;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] rs;
        logic [1:0] imm;
        logic [2:0] alu;
        logic       ill;
    } ov_t;

    typedef struct packed {
        logic mr;
        logic zf;
        logic sf;
        ov_t  ov;
    } step_t;

    ov_t   obs;
    step_t plan[$];
    int    n_chk = 0;
    int    n_fail = 0;

    assign obs = {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB,
                  ResultSrc, ImmSrc, ALUControl, illegal_op};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // ---- reference model: what each instruction class must look like, cycle by cycle ----
    function automatic logic [1:0] imm_of(input logic [6:0] op);
        if (op == 7'b0100011) return 2'b01;
        if (op == 7'b1100011) return 2'b10;
        if (op == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic sub);
        logic [2:0] code [8];
        code = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b100, 3'b101, 3'b110, 3'b111};
        if (f3 == 3'd0 && sub) return 3'b010;
        return code[f3];
    endfunction

    task automatic push(input logic mr, input logic zf, input logic sf, input ov_t o);
        step_t s;
        s.mr = mr;
        s.zf = zf;
        s.sf = sf;
        s.ov = o;
        plan.push_back(s);
    endtask

    task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic zf, input logic sf, input int fw, input int mw);
        ov_t  b, o;
        logic legal, is_r, is_i;
        plan.delete();
        b = '0;
        b.imm = imm_of(op);
        is_r = (op == 7'b0110011);
        is_i = (op == 7'b0010011);
        legal = (op == 7'b0000011) || (op == 7'b0100011) || is_r || is_i || (op == 7'b1100011);
`ifdef MC_JAL_EN
        legal = legal || (op == 7'b1101111);
`endif
        // fetch: PC+4 on the ALU; IR and PC load only on the ready cycle
        o = b; o.sb = 2'b10; o.rs = 2'b10;
        for (int i = 0; i < fw; i++) push(1'b0, zf, sf, o);
        o.pcw = 1'b1; o.irw = 1'b1;
        push(1'b1, zf, sf, o);
        // decode: OldPC + imm as speculative branch target
        o = b; o.sa = 2'b01; o.sb = 2'b01; o.ill = !legal;
        push(1'($urandom), zf, sf, o);
        if (!legal) return;
        if (op == 7'b0000011 || op == 7'b0100011) begin
            o = b; o.sa = 2'b10; o.sb = 2'b01;
            push(1'($urandom), zf, sf, o);
            o = b; o.adr = 1'b1; o.mw = (op == 7'b0100011);
            for (int i = 0; i < mw; i++) push(1'b0, zf, sf, o);
            push(1'b1, zf, sf, o);
            if (op == 7'b0000011) begin
                o = b; o.rs = 2'b01; o.rw = 1'b1;
                push(1'($urandom), zf, sf, o);
            end
        end else if (is_r || is_i) begin
            o = b; o.sa = 2'b10; o.sb = is_i ? 2'b01 : 2'b00;
            o.alu = alu_of(f3, f7 && is_r);
            o.ill = (f3 == 3'd2) || (f3 == 3'd3);
            push(1'($urandom), zf, sf, o);
            if (!o.ill) begin
                o = b; o.rw = 1'b1;
                push(1'($urandom), zf, sf, o);
            end
        end else if (op == 7'b1100011) begin
            o = b; o.sa = 2'b10; o.alu = 3'b010;
            o.pcw = (f3 == 3'd0 && zf) || (f3 == 3'd1 && !zf) || (f3 == 3'd4 && sf);
            push(1'($urandom), zf, sf, o);
        end else begin
            // jal: OldPC + 4 is the link value, jump target already in ALUOut
            o = b; o.sa = 2'b01; o.sb = 2'b10; o.pcw = 1'b1;
            push(1'($urandom), zf, sf, o);
            o = b; o.rw = 1'b1;
            push(1'($urandom), zf, sf, o);
        end
    endtask

    task automatic instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                         input logic f7, input logic zf, input logic sf,
                         input int fw, input int mw, input int nsteps);
        build(op, f3, f7, zf, sf, fw, mw);
        for (int k = 0; k < plan.size() && (nsteps < 0 || k < nsteps); k++) begin
            @(negedge clk);
            if (k == 0) begin
                opcode   = op;
                funct3   = f3;
                funct7b5 = f7;
            end
            mem_ready = plan[k].mr;
            ZF        = plan[k].zf;
            SF        = plan[k].sf;
            #2 chk($sformatf("%s c%0d", name, k), 32'(obs), 32'(plan[k].ov));
        end
    endtask

    initial begin
        logic [6:0] ops [7];
        logic [6:0] rop;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b1111111};

        // reset state: everything 0 even with mem_ready high
        repeat (2) @(negedge clk);
        #2 chk("reset", 32'(obs), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        instr("fetch_wait", 7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 3, 0, -1);
        instr("add",        7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0, -1);
        instr("sub",        7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 0, 0, -1);
        instr("addi_b30",   7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0, 0, 0, -1);
        instr("beq_z",      7'b1100011, 3'b000, 1'b0, 1'b1, 1'b0, 0, 0, -1);
        instr("bne_z",      7'b1100011, 3'b001, 1'b0, 1'b1, 1'b0, 0, 0, -1);
        instr("blt_s",      7'b1100011, 3'b100, 1'b0, 1'b0, 1'b1, 0, 0, -1);
        instr("bge_s",      7'b1100011, 3'b101, 1'b0, 1'b1, 1'b1, 0, 0, -1);
        instr("sw_wait",    7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 0, 2, -1);
        instr("lw_wait",    7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1, 2, -1);
        instr("slt_ill",    7'b0110011, 3'b010, 1'b0, 1'b0, 1'b0, 0, 0, -1);
        instr("illegal",    7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0, -1);
        instr("jal",        7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0, -1);

        // reset in the middle of a load's MEMREAD wait
        instr("lw_cut",     7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 0, 3, 4);
        #1 rst_n = 1'b0;
        #1 chk("rst_mid", 32'(obs), 32'd0);
        @(negedge clk);
        #2 chk("rst_hold", 32'(obs), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        instr("after_rst",  7'b0110011, 3'b111, 1'b0, 1'b0, 1'b0, 0, 0, -1);

        // randomized instruction stream
        for (int n = 0; n < 300; n++) begin
            int sel;
            sel = int'($urandom_range(0, 7));
            rop = (sel == 7) ? 7'($urandom) : ops[sel];
            instr($sformatf("rnd%0d", n), rop, 3'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), -1);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port opcode, input, 7 bits: instruction register bits [6:0].
REQ-004 SHALL have port funct3, input, 3 bits: instruction register bits [14:12].
REQ-005 SHALL have port funct7b5, input, 1 bit: instruction register bit 30.
REQ-006 SHALL have port ZF, input, 1 bit: ALU zero flag.
REQ-007 SHALL have port SF, input, 1 bit: ALU sign flag.
REQ-008 SHALL have port mem_ready, input, 1 bit: memory access completes this cycle.
REQ-009 SHALL have outputs PCWrite, IRWrite, RegWrite, MemWrite and AdrSrc, 1 bit each: datapath enables and selects.
REQ-010 SHALL have outputs ALUSrcA, ALUSrcB, ResultSrc and ImmSrc, 2 bits each: datapath mux selects.
REQ-011 SHALL have output ALUControl, 3 bits, with encoding add=000, sll=001, sub=010, xor=100, srl=101, or=110, and=111.
REQ-012 SHALL have output illegal_op, 1 bit: one-cycle pulse on an unsupported instruction.

Function
REQ-013 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH and JAL; the only exceptions are PCWrite and IRWrite, which depend on mem_ready, ZF and SF as stated below.
REQ-014 SHALL use these mux encodings: ALUSrcA 00=PC, 01=OldPC, 10=A; ALUSrcB 00=B, 01=ImmExt, 10=const 4; ResultSrc 00=ALUOut, 01=Data, 10=ALUResult; AdrSrc 0=PC, 1=Result.
REQ-015 In FETCH it SHALL drive AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUControl=add and ResultSrc=10; it SHALL drive IRWrite=PCWrite=mem_ready, and SHALL stay in FETCH while mem_ready=0, otherwise go to DECODE.
REQ-016 In DECODE it SHALL drive ALUSrcA=01, ALUSrcB=01 and add (branch target), and SHALL dispatch on opcode: 0000011 or 0100011 to MEMADR, 0110011 to EXECR, 0010011 to EXECI, 1100011 to BRANCH, 1101111 to JAL.
REQ-017 In DECODE any other opcode SHALL return to FETCH with illegal_op=1 for that cycle.
REQ-018 In MEMADR it SHALL drive A + ImmExt (add), then go to MEMREAD for a load or MEMWRITE for a store.
REQ-019 In MEMREAD it SHALL drive AdrSrc=1 and ResultSrc=00, hold until mem_ready=1, then go to MEMWB; MEMWB SHALL drive ResultSrc=01 and RegWrite=1, then go to FETCH.
REQ-020 In MEMWRITE it SHALL drive AdrSrc=1, ResultSrc=00 and MemWrite=1, hold while mem_ready=0, then go to FETCH.
REQ-021 EXECR SHALL drive A op B and EXECI SHALL drive A op ImmExt, with op from the ALU decoder; both SHALL then go to ALUWB; ALUWB SHALL drive ResultSrc=00 and RegWrite=1, then go to FETCH.
REQ-022 The ALU decoder SHALL map funct3 000 to sub when R-type and funct7b5=1, otherwise add; 001 to sll; 100 to xor; 101 to srl; 110 to or; 111 to and.
REQ-023 In EXECR or EXECI, funct3 010 or 011 SHALL assert illegal_op, suppress RegWrite and return to FETCH.
REQ-024 BRANCH SHALL drive A - B (sub) and ResultSrc=00, and SHALL set PCWrite = taken, where taken is ZF for funct3 000, !ZF for 001, SF for 100 and 0 otherwise; it SHALL then go to FETCH.
REQ-025 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00 and PCWrite=1, then go to ALUWB.
REQ-026 ImmSrc SHALL be 00 for I-type/load, 01 for store, 10 for branch and 11 for jal, decoded from opcode in every state.
REQ-027 Every output not listed for a state SHALL be 0.

Reset
REQ-028 Asserting rst_n low at any time, including mid-access, SHALL force FETCH asynchronously with all enables 0; the first fetch SHALL start on the first clk edge after release.

Configuration
REQ-029 With MC_JAL_EN defined, the JAL state and opcode 1101111 SHALL be supported; without it, 1101111 SHALL be treated as illegal per REQ-017 and the JAL state SHALL not exist.

Structure
REQ-030 A shared package SHALL hold the state encoding, ALUControl codes, mux-select codes and opcode constants.
REQ-031 A combinational sub-module alu_decoder SHALL map ALUOp (00 add, 01 sub, 10 funct) plus funct3 and funct7b5 to ALUControl.

Verification
REQ-032 Reset then mem_ready=0 for 3 cycles -> FETCH held, IRWrite=PCWrite=0 for those cycles, 1 on the cycle mem_ready rises.
REQ-033 add x (opcode 0110011, funct3 000, funct7b5=0) -> FETCH, DECODE, EXECR (ALUControl=000), ALUWB (RegWrite=1): 4 cycles with mem_ready=1.
REQ-034 beq with ZF=1 -> PCWrite=1 in BRANCH; bne with ZF=1 -> PCWrite=0; blt with SF=1 -> PCWrite=1.
REQ-035 sw with mem_ready low 2 cycles -> MemWrite=1 held for 3 cycles, then FETCH.
REQ-036 opcode 1111111 -> illegal_op pulses once in DECODE, next state FETCH, no RegWrite.
REQ-037 rst_n low during MEMREAD -> outputs 0 immediately, FETCH after release.
